// File: rtl/bitrev_reorder.sv
// Bit-reversed to natural-order reorder buffer for FFT outputs.
// Two ping-pong banks: one frame is written while the other is read.
module bitrev_reorder #(
  parameter int N = 3,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_real,
  input  logic [W-1:0] in_img,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_real,
  output logic [W-1:0] out_img,
  output logic         out_first,
  output logic         out_last
);

  localparam int DEPTH = 1 << N;
  localparam logic [N-1:0] CNT_MAX = '1;

  logic signed [W-1:0] mem_re [2*DEPTH];
  logic signed [W-1:0] mem_im [2*DEPTH];

  logic [N-1:0] wr_cnt;
  logic [N-1:0] rd_cnt;
  logic         wr_bank;
  logic         rd_bank;
  logic [1:0]   full;
  logic [1:0]   full_nxt;
  logic         wr_fire;
  logic         rd_fire;
  logic [N:0]   wr_addr;
  logic [N:0]   rd_addr;

  function automatic logic [N-1:0] bitrev(input logic [N-1:0] v);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i] = v[N-1-i];
    return r;
  endfunction

  // in_ready depends only on registered state, never on in_valid
  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;
  assign wr_addr   = {wr_bank, bitrev(wr_cnt)};
  assign rd_addr   = {rd_bank, rd_cnt};

  // Sample storage: data path only, no reset
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_re[wr_addr] <= in_real;
      mem_im[wr_addr] <= in_img;
    end
  end

  assign out_real  = mem_re[rd_addr];
  assign out_img   = mem_im[rd_addr];
  assign out_first = out_valid && (rd_cnt == '0);
  assign out_last  = out_valid && (rd_cnt == CNT_MAX);

  // Write and read sides always touch different banks, so both edits apply
  always_comb begin
    full_nxt = full;
    if (wr_fire && wr_cnt == CNT_MAX) full_nxt[wr_bank] = 1'b1;
    if (rd_fire && rd_cnt == CNT_MAX) full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full    <= 2'b00;
    end else begin
      full <= full_nxt;
      if (wr_fire) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_cnt == CNT_MAX) wr_bank <= !wr_bank;
      end
      if (rd_fire) begin
        rd_cnt <= rd_cnt + 1'b1;
        if (rd_cnt == CNT_MAX) rd_bank <= !rd_bank;
      end
    end
  end

endmodule

// File: tb/tb_bitrev_reorder.sv
// Scoreboard bench for bitrev_reorder: N=3 main instance plus an N=1 instance.
module tb_bitrev_reorder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_first, out_last;
  logic [15:0] in_real, in_img, out_real, out_img;

  logic        n1_in_valid, n1_in_ready, n1_out_valid, n1_out_ready, n1_out_first, n1_out_last;
  logic [15:0] n1_in_real, n1_in_img, n1_out_real, n1_out_img;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    logic        first;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] fbuf_re[8];
  logic [15:0] fbuf_im[8];
  int          wcnt = 0;
  int          wait_cycles = 0;

  logic        stall_q = 1'b0;
  logic [15:0] hold_re, hold_im;
  logic        hold_first, hold_last;

  always #5 clk = ~clk;

  bitrev_reorder #(.N(3), .W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_img(in_img),
    .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real), .out_img(out_img),
    .out_first(out_first), .out_last(out_last)
  );

  bitrev_reorder #(.N(1), .W(16)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(n1_in_valid), .in_ready(n1_in_ready), .in_real(n1_in_real), .in_img(n1_in_img),
    .out_valid(n1_out_valid), .out_ready(n1_out_ready), .out_real(n1_out_real),
    .out_img(n1_out_img), .out_first(n1_out_first), .out_last(n1_out_last)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rev3(input int j);
    return ((j & 1) << 2) | (j & 2) | ((j >> 2) & 1);
  endfunction

  // Drive one sample; returns at posedge+1 of the accepting edge
  task automatic write_sample(input logic [15:0] re, input logic [15:0] im);
    bit accepted;
    accepted = 0;
    in_valid = 1'b1;
    in_real  = re;
    in_img   = im;
    for (int t = 0; t < 300 && !accepted; t++) begin
      @(negedge clk);
      if (in_ready) accepted = 1;
      else wait_cycles++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!accepted) begin
      check("write_timeout", 32'd0, 32'd1);
    end else begin
      fbuf_re[wcnt] = re;
      fbuf_im[wcnt] = im;
      wcnt++;
      if (wcnt == 8) begin
        for (int j = 0; j < 8; j++) begin
          exp_t e;
          e.re    = fbuf_re[rev3(j)];
          e.im    = fbuf_im[rev3(j)];
          e.first = (j == 0);
          e.last  = (j == 7);
          sb.push_back(e);
        end
        wcnt = 0;
      end
    end
  endtask

  task automatic write_frame(input int base);
    for (int k = 0; k < 8; k++) write_sample(16'(base + k), 16'(-(base + k)));
  endtask

  task automatic drain();
    for (int t = 0; t < 400; t++) begin
      if (sb.size() == 0 && !out_valid) break;
      @(posedge clk);
      #1;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
    check("drain_valid", 32'(out_valid), 32'd0);
  endtask

  // Output monitor: pops the scoreboard on each read handshake
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_real", 32'(out_real), 32'(hold_re));
        check("hold_img", 32'(out_img), 32'(hold_im));
        check("hold_first", 32'(out_first), 32'(hold_first));
        check("hold_last", 32'(out_last), 32'(hold_last));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 32'(out_real), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_real", 32'(out_real), 32'(e.re));
          check("out_img", 32'(out_img), 32'(e.im));
          check("out_first", 32'(out_first), 32'(e.first));
          check("out_last", 32'(out_last), 32'(e.last));
        end
      end
      stall_q    = out_valid && !out_ready;
      hold_re    = out_real;
      hold_im    = out_img;
      hold_first = out_first;
      hold_last  = out_last;
    end
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_real = '0; in_img = '0; out_ready = 1'b1;
    n1_in_valid = 1'b0; n1_in_real = '0; n1_in_img = '0; n1_out_ready = 1'b1;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_first", 32'(out_first), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single frame, latency and order
    for (int k = 0; k < 7; k++) write_sample(16'(k), 16'(-k));
    check("pre_last_valid", 32'(out_valid), 32'd0);
    write_sample(16'd7, 16'hFFF9);
    check("latency_valid", 32'(out_valid), 32'd1);
    check("latency_first", 32'(out_first), 32'd1);
    check("latency_real", 32'(out_real), 32'd0);
    drain();

    // Three back-to-back frames, no input stall allowed
    wait_cycles = 0;
    for (int f = 0; f < 3; f++) write_frame(16 + f * 8);
    check("b2b_no_stall", 32'(wait_cycles), 32'd0);
    drain();

    // Two frames buffered with output blocked, extra sample rejected
    out_ready = 1'b0;
    write_frame(64);
    write_frame(72);
    check("full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_real = 16'h0099; in_img = 16'h0099;
    repeat (3) @(posedge clk);
    #1;
    check("full_hold_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    write_frame(80);
    drain();

    // Random backpressure across three frames
    fork
      begin
        for (int f = 0; f < 3; f++) write_frame(100 + f * 8);
      end
      begin
        for (int t = 0; t < 120; t++) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with one frame buffered and a partial frame in progress
    out_ready = 1'b0;
    write_frame(200);
    for (int k = 0; k < 5; k++) write_sample(16'(300 + k), 16'(-(300 + k)));
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_first", 32'(out_first), 32'd0);
    sb.delete();
    wcnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    write_frame(400);
    drain();

    // N=1 instance: 0,1 in, 0,1 out on consecutive cycles
    n1_in_valid = 1'b1; n1_in_real = 16'd0; n1_in_img = 16'd0;
    @(posedge clk); #1;
    n1_in_real = 16'd1; n1_in_img = 16'hFFFF;
    @(posedge clk); #1;
    n1_in_valid = 1'b0;
    check("n1_valid0", 32'(n1_out_valid), 32'd1);
    check("n1_real0", 32'(n1_out_real), 32'd0);
    check("n1_first0", 32'(n1_out_first), 32'd1);
    check("n1_last0", 32'(n1_out_last), 32'd0);
    @(posedge clk); #1;
    check("n1_valid1", 32'(n1_out_valid), 32'd1);
    check("n1_real1", 32'(n1_out_real), 32'd1);
    check("n1_img1", 32'(n1_out_img), 32'hFFFF);
    check("n1_first1", 32'(n1_out_first), 32'd0);
    check("n1_last1", 32'(n1_out_last), 32'd1);
    @(posedge clk); #1;
    check("n1_valid_end", 32'(n1_out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitrev_reorder.md
BITREV_REORDER -- requirements
Module: bitrev_reorder

Interface
REQ-001 Parameter N, default 3: FFT size is 2^N points; legal range 1..10.
REQ-002 Parameter W, default 16: two's-complement width of each real and imaginary sample.
REQ-003 clk  in  1  single clock for all state; every register updates on posedge clk.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 in_valid  in  1  input sample present.
REQ-006 in_ready  out  1  block can accept an input sample this cycle.
REQ-007 in_real, in_img  in  W each  sample from the last butterfly stage, arriving in bit-reversed order.
REQ-008 out_valid  out  1  output sample present.
REQ-009 out_ready  in  1  downstream accepts the output sample this cycle.
REQ-010 out_real, out_img  out  W each  sample in natural index order.
REQ-011 out_first, out_last  out  1 each  marks output index 0 and index 2^N-1 of a frame; each is qualified by out_valid.

Function
REQ-012 Storage SHALL be two ping-pong banks of 2^N complex words each; a bank is selected by bit wr_bank on the write side and bit rd_bank on the read side; each bank has one full flag, full[1:0].
REQ-013 A write handshake is in_valid && in_ready; in_ready SHALL equal !full[wr_bank], decoded from registers only, with no combinational path from in_valid.
REQ-014 On each write, the sample SHALL be stored at address bitrev_N(wr_cnt) of bank wr_bank, where bitrev_N reverses the N LSBs; wr_cnt (N bits) then increments.
REQ-015 On the write with wr_cnt == 2^N-1, wr_cnt SHALL wrap to 0, full[wr_bank] SHALL be set, and wr_bank SHALL toggle.
REQ-016 out_valid SHALL equal full[rd_bank]; out_real and out_img SHALL equal word rd_cnt of bank rd_bank (asynchronous read of registered addresses).
REQ-017 A read handshake is out_valid && out_ready, and it advances rd_cnt; out_valid high with out_ready low SHALL hold all out_* stable.
REQ-018 On the read with rd_cnt == 2^N-1, rd_cnt SHALL wrap to 0, full[rd_bank] SHALL clear, and rd_bank SHALL toggle.
REQ-019 out_first = out_valid && rd_cnt == 0; out_last = out_valid && rd_cnt == 2^N-1.
REQ-020 Latency: the first out_valid of a frame SHALL be asserted in the cycle after that frame's last input write.
REQ-021 If a write sets full on one bank and a read clears full on the other bank in the same cycle, both updates SHALL take effect.
REQ-022 A bank freed by a read SHALL raise in_ready no earlier than the following cycle.
REQ-023 Sustained throughput with out_ready held high SHALL be 1 sample per cycle, with no bubble between frames.
REQ-024 Both full flags set SHALL hold in_ready low; input data presented while in_ready is low SHALL be neither stored nor counted.
REQ-025 Data paths SHALL be pass-through: no arithmetic, rounding or width change.

Reset
REQ-026 While rst_n is low: wr_cnt = rd_cnt = 0, wr_bank = rd_bank = 0, full = 2'b00, in_ready = 1, out_valid = out_first = out_last = 0.
REQ-027 Asserting rst_n mid-frame SHALL discard the partial frame and all buffered frames; memory contents need not be cleared.
REQ-028 After rst_n is released, the first accepted sample SHALL be treated as index 0 of a new frame.

Verification
REQ-029 N=3, out_ready=1, 8 writes in_real=k, in_img=-k for k=0..7 -> out_real sequence 0,4,2,6,1,5,3,7 with out_img negated; out_first on the 1st sample, out_last on the 8th; out_valid rises the cycle after the 8th write.
REQ-030 3 back-to-back frames with out_ready=1 and in_valid held high -> in_ready never drops; 24 outputs are contiguous, each frame reordered as in REQ-029.
REQ-031 out_ready=0 while 2 frames are written -> in_ready low after the 16th write; a 17th presented sample is ignored; setting out_ready=1 -> frame 0 is output, then frame 1, both intact.
REQ-032 out_ready toggled pseudo-randomly -> out_* stable while stalled; no sample lost or duplicated; order is correct.
REQ-033 rst_n pulsed low after 5 writes of a frame -> outputs clear immediately; a fresh 8-sample frame after release emits only that frame's data, correctly ordered.
REQ-034 N=1 -> input 0,1 emits 0,1; out_first and out_last on consecutive samples.
